tag_reg_file: RTL and testbench

Parametrised register file with an integrated register-status (tag) table for the Tomasulo-style out-of-order core. It sits between the issue/decode unit and the reservation stations and load/store unit. Issue slots rename destination registers to producer tags, and common-data-bus (CDB) writebacks retire those tags. Read ports return either a ready value or the pending tag, with same-cycle CDB bypass. It replaces the fixed 4-register, 8-bit, dual-issue file with one generalised in register count, width, issue width, CDB count and read-port count, and adds flush and error reporting.

---
 rtl/ooo_pkg.sv | 13 +
 rtl/tag_reg_entry.sv | 59 +++++
 rtl/tag_reg_file.sv | 157 +++++++++++++++
 tb/tb_tag_reg_file.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// rtl/ooo_pkg.sv - shared out-of-order core constants and index-width helper
package ooo_pkg;

  localparam int NUM_REG_DEF  = 4;
  localparam int DATA_WID_DEF = 8;
  localparam int TAG_LEN_DEF  = 4;
  localparam int TAG_NONE     = 0;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tag_reg_entry.sv
// rtl/tag_reg_entry.sv - one register: data, busy bit and producer tag
module tag_reg_entry
  import ooo_pkg::*;
#(
  parameter int DATA_WID = DATA_WID_DEF,
  parameter int TAG_LEN  = TAG_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                ren,
  input  logic [TAG_LEN-1:0]  ren_tag,
  input  logic                cdb_hit,
  input  logic [DATA_WID-1:0] cdb_data,
  output logic [DATA_WID-1:0] data,
  output logic                busy,
  output logic [TAG_LEN-1:0]  tag
);

  logic [DATA_WID-1:0] data_q, data_d;
  logic                busy_q, busy_d;
  logic [TAG_LEN-1:0]  tag_q, tag_d;

  // Applied in order so a same-cycle rename overrides both flush and writeback.
  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (flush) begin
      busy_d = 1'b0;
      tag_d  = '0;
    end
    if (cdb_hit) begin
      data_d = cdb_data;
      busy_d = 1'b0;
    end
    if (ren) begin
      busy_d = 1'b1;
      tag_d  = ren_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      busy_q <= 1'b0;
      tag_q  <= '0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  assign data = data_q;
  assign busy = busy_q;
  assign tag  = tag_q;

endmodule

// File: rtl/tag_reg_file.sv
// rtl/tag_reg_file.sv - register file with rename tag table, CDB writeback and bypass reads
module tag_reg_file
  import ooo_pkg::*;
#(
  parameter int NUM_REG     = NUM_REG_DEF,
  parameter int DATA_WID    = DATA_WID_DEF,
  parameter int TAG_LEN     = TAG_LEN_DEF,
  parameter int ISSUE_WIDTH = 2,
  parameter int NUM_CDB     = 3,
  parameter int NUM_RD      = 4,
  localparam int IDX_W      = idx_width(NUM_REG)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ISSUE_WIDTH-1:0]      iss_val,
  input  logic [ISSUE_WIDTH*IDX_W-1:0] iss_dest,
  input  logic [ISSUE_WIDTH*TAG_LEN-1:0] iss_tag,
  input  logic [NUM_CDB-1:0]          cdb_val,
  input  logic [NUM_CDB*TAG_LEN-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_WID-1:0] cdb_data,
  input  logic                        flush,
  input  logic [NUM_RD*IDX_W-1:0]     rd_idx,
  output logic [NUM_RD-1:0]           rd_busy,
  output logic [NUM_RD*TAG_LEN-1:0]   rd_tag,
  output logic [NUM_RD*DATA_WID-1:0]  rd_data,
  output logic [NUM_REG-1:0]          busy_vec,
  output logic                        err
);

  logic [IDX_W-1:0]    dest_a   [ISSUE_WIDTH];
  logic [TAG_LEN-1:0]  itag_a   [ISSUE_WIDTH];
  logic [TAG_LEN-1:0]  ctag_a   [NUM_CDB];
  logic [DATA_WID-1:0] cdata_a  [NUM_CDB];
  logic [IDX_W-1:0]    rd_idx_a [NUM_RD];

  for (genvar s = 0; s < ISSUE_WIDTH; s++) begin : g_iss
    assign dest_a[s] = iss_dest[s*IDX_W +: IDX_W];
    assign itag_a[s] = iss_tag[s*TAG_LEN +: TAG_LEN];
  end
  for (genvar k = 0; k < NUM_CDB; k++) begin : g_cdb
    assign ctag_a[k]  = cdb_tag[k*TAG_LEN +: TAG_LEN];
    assign cdata_a[k] = cdb_data[k*DATA_WID +: DATA_WID];
  end
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rd_idx_a[p] = rd_idx[p*IDX_W +: IDX_W];
  end

  logic [ISSUE_WIDTH-1:0] slot_ok;
  logic                   slot_bad, iss_dup, cdb_dup;

  // Duplicate issue tags would leave two registers waiting on one producer, so both slots drop.
  always_comb begin
    slot_ok  = '0;
    slot_bad = 1'b0;
    iss_dup  = 1'b0;
    cdb_dup  = 1'b0;
    for (int s = 0; s < ISSUE_WIDTH; s++) begin
      slot_ok[s] = iss_val[s] && (itag_a[s] != TAG_LEN'(TAG_NONE)) &&
                   (int'(dest_a[s]) < NUM_REG);
      if (iss_val[s] && !slot_ok[s]) slot_bad = 1'b1;
    end
    for (int s = 0; s < ISSUE_WIDTH; s++) begin
      for (int t = s + 1; t < ISSUE_WIDTH; t++) begin
        if (iss_val[s] && iss_val[t] && (itag_a[s] == itag_a[t])) begin
          iss_dup    = 1'b1;
          slot_ok[s] = 1'b0;
          slot_ok[t] = 1'b0;
        end
      end
    end
    for (int j = 0; j < NUM_CDB; j++) begin
      for (int k = j + 1; k < NUM_CDB; k++) begin
        if (cdb_val[j] && cdb_val[k] && (ctag_a[j] != TAG_LEN'(TAG_NONE)) &&
            (ctag_a[j] == ctag_a[k])) cdb_dup = 1'b1;
      end
    end
  end

  logic [NUM_REG-1:0]  ren_r, hit_r, busy_r;
  logic [TAG_LEN-1:0]  ren_tag_r  [NUM_REG];
  logic [TAG_LEN-1:0]  tag_r      [NUM_REG];
  logic [DATA_WID-1:0] hit_data_r [NUM_REG];
  logic [DATA_WID-1:0] data_r     [NUM_REG];

  // Ascending slot scan lets the later slot win; descending CDB scan lets the lowest bus win.
  always_comb begin
    ren_r = '0;
    hit_r = '0;
    for (int r = 0; r < NUM_REG; r++) begin
      ren_tag_r[r]  = '0;
      hit_data_r[r] = '0;
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
        if (slot_ok[s] && (dest_a[s] == IDX_W'(r))) begin
          ren_r[r]     = 1'b1;
          ren_tag_r[r] = itag_a[s];
        end
      end
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
        if (busy_r[r] && cdb_val[k] && (ctag_a[k] != TAG_LEN'(TAG_NONE)) &&
            (ctag_a[k] == tag_r[r])) begin
          hit_r[r]      = 1'b1;
          hit_data_r[r] = cdata_a[k];
        end
      end
    end
  end

  for (genvar r = 0; r < NUM_REG; r++) begin : g_entry
    tag_reg_entry #(
      .DATA_WID (DATA_WID),
      .TAG_LEN  (TAG_LEN)
    ) u_entry (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .ren      (ren_r[r]),
      .ren_tag  (ren_tag_r[r]),
      .cdb_hit  (hit_r[r]),
      .cdb_data (hit_data_r[r]),
      .data     (data_r[r]),
      .busy     (busy_r[r]),
      .tag      (tag_r[r])
    );
  end

  always_comb begin
    rd_busy = '0;
    rd_tag  = '0;
    rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (int'(rd_idx_a[p]) < NUM_REG) begin
        if (hit_r[rd_idx_a[p]]) begin
          rd_data[p*DATA_WID +: DATA_WID] = hit_data_r[rd_idx_a[p]];
        end else begin
          rd_busy[p]                      = busy_r[rd_idx_a[p]];
          rd_tag[p*TAG_LEN +: TAG_LEN]    = busy_r[rd_idx_a[p]] ? tag_r[rd_idx_a[p]] : '0;
          rd_data[p*DATA_WID +: DATA_WID] = data_r[rd_idx_a[p]];
        end
      end
    end
  end

  logic err_q, err_d;

  always_comb begin
    err_d = slot_bad | iss_dup | cdb_dup;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign busy_vec = busy_r;
  assign err      = err_q;

endmodule

// File: tb/tb_tag_reg_file.sv
// tb/tb_tag_reg_file.sv - self-checking bench for tag_reg_file
module tb_tag_reg_file;
  localparam int NR = 4, DW = 8, TL = 4, IW = 2, NC = 3, NRD = 4, XW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [IW-1:0]     iss_val;
  logic [IW*XW-1:0]  iss_dest;
  logic [IW*TL-1:0]  iss_tag;
  logic [NC-1:0]     cdb_val;
  logic [NC*TL-1:0]  cdb_tag;
  logic [NC*DW-1:0]  cdb_data;
  logic              flush;
  logic [NRD*XW-1:0] rd_idx;
  logic [NRD-1:0]    rd_busy;
  logic [NRD*TL-1:0] rd_tag;
  logic [NRD*DW-1:0] rd_data;
  logic [NR-1:0]     busy_vec;
  logic              err;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] m_data [NR];
  logic          m_busy [NR];
  logic [TL-1:0] m_tag  [NR];
  logic          m_err;

  always #5 clk = ~clk;

  tag_reg_file dut (
    .clk(clk), .rst(rst), .iss_val(iss_val), .iss_dest(iss_dest), .iss_tag(iss_tag),
    .cdb_val(cdb_val), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .flush(flush),
    .rd_idx(rd_idx), .rd_busy(rd_busy), .rd_tag(rd_tag), .rd_data(rd_data),
    .busy_vec(busy_vec), .err(err)
  );

  function automatic logic [TL-1:0] rdt(input int p); return rd_tag[p*TL +: TL]; endfunction
  function automatic logic [DW-1:0] rdd(input int p); return rd_data[p*DW +: DW]; endfunction
  function automatic logic [TL-1:0] itag(input int s); return iss_tag[s*TL +: TL]; endfunction
  function automatic int idest(input int s); return int'(iss_dest[s*XW +: XW]); endfunction
  function automatic logic [TL-1:0] ctag(input int k); return cdb_tag[k*TL +: TL]; endfunction
  function automatic logic [DW-1:0] cdat(input int k); return cdb_data[k*DW +: DW]; endfunction

  task automatic idle();
    iss_val = '0; iss_dest = '0; iss_tag = '0;
    cdb_val = '0; cdb_tag = '0; cdb_data = '0;
    flush = 1'b0; rd_idx = '0;
  endtask

  task automatic rename(input int s, input int d, input int t);
    iss_val[s] = 1'b1;
    iss_dest[s*XW +: XW] = XW'(d);
    iss_tag[s*TL +: TL] = TL'(t);
  endtask

  task automatic cdb(input int k, input int t, input int d);
    cdb_val[k] = 1'b1;
    cdb_tag[k*TL +: TL] = TL'(t);
    cdb_data[k*DW +: DW] = DW'(d);
  endtask

  task automatic rd(input int p, input int idx);
    rd_idx[p*XW +: XW] = XW'(idx);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    for (int r = 0; r < NR; r++) begin
      m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
    end
    m_err = 1'b0;
    #2;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // Reference model: what a read should return given stored state and current buses.
  task automatic model_read(input int idx, output logic b, output logic [TL-1:0] t,
                            output logic [DW-1:0] d);
    logic found;
    b = 1'b0; t = '0; d = '0; found = 1'b0;
    if (idx < NR) begin
      b = m_busy[idx];
      t = m_busy[idx] ? m_tag[idx] : '0;
      d = m_data[idx];
      if (m_busy[idx]) begin
        for (int k = 0; k < NC; k++) begin
          if (!found && cdb_val[k] && ctag(k) != 0 && ctag(k) == m_tag[idx]) begin
            found = 1'b1; b = 1'b0; t = '0; d = cdat(k);
          end
        end
      end
    end
  endtask

  task automatic model_step();
    logic [DW-1:0] nd [NR];
    logic          nb [NR];
    logic [TL-1:0] nt [NR];
    logic          ok [IW];
    logic          e, found;
    e = 1'b0;
    for (int r = 0; r < NR; r++) begin
      nd[r] = m_data[r]; nb[r] = m_busy[r]; nt[r] = m_tag[r];
      found = 1'b0;
      if (m_busy[r]) begin
        for (int k = 0; k < NC; k++) begin
          if (!found && cdb_val[k] && ctag(k) != 0 && ctag(k) == m_tag[r]) begin
            found = 1'b1; nd[r] = cdat(k); nb[r] = 1'b0;
          end
        end
      end
      if (flush) begin nb[r] = 1'b0; nt[r] = '0; end
    end
    for (int s = 0; s < IW; s++) begin
      ok[s] = iss_val[s] && itag(s) != 0 && idest(s) < NR;
      if (iss_val[s] && !ok[s]) e = 1'b1;
    end
    for (int s = 0; s < IW; s++)
      for (int t = s + 1; t < IW; t++)
        if (iss_val[s] && iss_val[t] && itag(s) == itag(t)) begin
          e = 1'b1; ok[s] = 1'b0; ok[t] = 1'b0;
        end
    for (int j = 0; j < NC; j++)
      for (int k = j + 1; k < NC; k++)
        if (cdb_val[j] && cdb_val[k] && ctag(j) != 0 && ctag(j) == ctag(k)) e = 1'b1;
    for (int s = 0; s < IW; s++)
      if (ok[s]) begin nb[idest(s)] = 1'b1; nt[idest(s)] = itag(s); end
    for (int r = 0; r < NR; r++) begin
      m_data[r] = nd[r]; m_busy[r] = nb[r]; m_tag[r] = nt[r];
    end
    m_err = e;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    for (int p = 0; p < NRD; p++) rd(p, p);
    #3;
    for (int p = 0; p < NRD; p++) begin
      checks++;
      if (rd_busy[p] !== 1'b0 || rdt(p) !== '0 || rdd(p) !== '0) begin
        failures++;
        $display("FAIL reset_rd%0d busy=%b tag=%h data=%h required 0/0/00", p, rd_busy[p], rdt(p), rdd(p));
      end
    end
    checks++;
    if (busy_vec !== 4'b0000 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state busy_vec=%b err=%b required 0000/0", busy_vec, err);
    end
    do_reset();
  endtask

  task automatic test_cdb_bypass();
    do_reset();
    rename(0, 2, 5); rd(0, 2); #1;
    checks++;
    if (rd_busy[0] !== 1'b0) begin
      failures++; $display("FAIL pre_rename_read busy=%b required 0", rd_busy[0]);
    end
    tick();
    idle(); cdb(0, 5, 8'h3C); rd(0, 2); #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || rdd(0) !== 8'h3C || busy_vec[2] !== 1'b1) begin
      failures++;
      $display("FAIL bypass busy=%b data=%h busy_vec=%b required 0/3c/x1xx", rd_busy[0], rdd(0), busy_vec);
    end
    tick();
    idle(); rd(0, 2); #1;
    checks++;
    if (busy_vec !== 4'b0000 || rd_busy[0] !== 1'b0 || rdd(0) !== 8'h3C) begin
      failures++;
      $display("FAIL writeback_stored busy_vec=%b busy=%b data=%h required 0000/0/3c", busy_vec, rd_busy[0], rdd(0));
    end
  endtask

  task automatic test_same_dest();
    do_reset();
    rename(0, 1, 3); rename(1, 1, 7);
    tick();
    idle(); rd(0, 1); cdb(0, 3, 8'hAA); #1;
    checks++;
    if (rd_busy[0] !== 1'b1 || rdt(0) !== 4'd7 || rdd(0) !== 8'h00) begin
      failures++;
      $display("FAIL same_dest_read busy=%b tag=%h data=%h required 1/7/00", rd_busy[0], rdt(0), rdd(0));
    end
    tick();
    idle(); rd(0, 1); #1;
    checks++;
    if (busy_vec !== 4'b0010 || rdt(0) !== 4'd7 || rdd(0) !== 8'h00) begin
      failures++;
      $display("FAIL same_dest_after busy_vec=%b tag=%h data=%h required 0010/7/00", busy_vec, rdt(0), rdd(0));
    end
  endtask

  task automatic test_rename_cdb();
    do_reset();
    rename(0, 0, 4);
    tick();
    idle(); cdb(0, 4, 8'h11); rename(0, 0, 9); rd(0, 0); #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || rdd(0) !== 8'h11) begin
      failures++; $display("FAIL rename_cdb_bypass busy=%b data=%h required 0/11", rd_busy[0], rdd(0));
    end
    tick();
    idle(); rd(0, 0); #1;
    checks++;
    if (rd_busy[0] !== 1'b1 || rdt(0) !== 4'd9 || rdd(0) !== 8'h11) begin
      failures++;
      $display("FAIL rename_cdb_state busy=%b tag=%h data=%h required 1/9/11", rd_busy[0], rdt(0), rdd(0));
    end
  endtask

  task automatic test_flush();
    do_reset();
    rename(0, 0, 1); rename(1, 1, 2);
    tick();
    idle(); cdb(0, 1, 8'h5A); cdb(1, 2, 8'hA5); rename(0, 0, 3); rename(1, 1, 4);
    tick();
    idle(); rename(0, 2, 5); rename(1, 3, 6);
    tick();
    idle(); #1;
    checks++;
    if (busy_vec !== 4'b1111) begin
      failures++; $display("FAIL flush_setup busy_vec=%b required 1111", busy_vec);
    end
    flush = 1'b1; rename(0, 3, 2);
    tick();
    idle(); rd(0, 0); rd(1, 1); rd(2, 3); #1;
    checks++;
    if (busy_vec !== 4'b1000 || rd_busy[2] !== 1'b1 || rdt(2) !== 4'd2) begin
      failures++;
      $display("FAIL flush_state busy_vec=%b r3_busy=%b r3_tag=%h required 1000/1/2", busy_vec, rd_busy[2], rdt(2));
    end
    checks++;
    if (rdd(0) !== 8'h5A || rdd(1) !== 8'hA5 || rdt(0) !== '0) begin
      failures++;
      $display("FAIL flush_data r0=%h r1=%h r0_tag=%h required 5a/a5/0", rdd(0), rdd(1), rdt(0));
    end
  endtask

  task automatic test_err();
    do_reset();
    rename(0, 1, 6);
    tick();
    idle(); rename(0, 2, 0); cdb(1, 6, 8'h77); cdb(2, 6, 8'h99); rd(0, 1); #1;
    checks++;
    if (err !== 1'b0 || rd_busy[0] !== 1'b0 || rdd(0) !== 8'h77) begin
      failures++;
      $display("FAIL err_cycle err=%b busy=%b data=%h required 0/0/77", err, rd_busy[0], rdd(0));
    end
    tick();
    idle(); rd(0, 1); #1;
    checks++;
    if (err !== 1'b1 || busy_vec !== 4'b0000 || rdd(0) !== 8'h77) begin
      failures++;
      $display("FAIL err_pulse err=%b busy_vec=%b data=%h required 1/0000/77", err, busy_vec, rdd(0));
    end
    rename(0, 0, 8); rename(1, 1, 8);
    tick();
    idle(); #1;
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL err_dup_issue err=%b required 1", err);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL err_clear err=%b required 0", err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rename(0, 0, 3); rename(1, 3, 4);
    tick();
    idle(); #1;
    checks++;
    if (busy_vec !== 4'b1001) begin
      failures++; $display("FAIL mid_setup busy_vec=%b required 1001", busy_vec);
    end
    rst = 1'b1; #1;
    checks++;
    if (busy_vec !== 4'b0000 || err !== 1'b0) begin
      failures++; $display("FAIL mid_reset busy_vec=%b err=%b required 0000/0", busy_vec, err);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic          eb;
    logic [TL-1:0] et;
    logic [DW-1:0] ed;
    logic [NR-1:0] ev;
    int t0, t1;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      idle();
      t0 = $urandom_range(1, 15);
      t1 = $urandom_range(1, 14);
      if (t1 >= t0) t1++;
      if ($urandom_range(0, 15) == 0) t0 = 0;
      if ($urandom_range(0, 1) == 1) rename(0, $urandom_range(0, 3), t0);
      if ($urandom_range(0, 1) == 1) rename(1, $urandom_range(0, 3), t1);
      for (int k = 0; k < NC; k++)
        if ($urandom_range(0, 2) != 0)
          cdb(k, ($urandom_range(0, 1) == 1) ? int'(m_tag[$urandom_range(0, 3)]) : $urandom_range(0, 15),
              $urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) begin
        flush = 1'b1;
        cdb_val = '0;
      end
      for (int p = 0; p < NRD; p++) rd(p, $urandom_range(0, 3));
      #1;
      for (int p = 0; p < NRD; p++) begin
        model_read(int'(rd_idx[p*XW +: XW]), eb, et, ed);
        checks++;
        if (rd_busy[p] !== eb || rdt(p) !== et || rdd(p) !== ed) begin
          failures++;
          $display("FAIL rand_read c=%0d p=%0d got %b/%h/%h required %b/%h/%h", c, p, rd_busy[p], rdt(p), rdd(p), eb, et, ed);
        end
      end
      for (int r = 0; r < NR; r++) ev[r] = m_busy[r];
      checks++;
      if (busy_vec !== ev || err !== m_err) begin
        failures++;
        $display("FAIL rand_state c=%0d busy_vec=%b err=%b required %b/%b", c, busy_vec, err, ev, m_err);
      end
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_cdb_bypass();
    test_same_dest();
    test_rename_cdb();
    test_flush();
    test_err();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
